// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
// Bridges a core request/response interface onto a single-port data memory
// with a registered read output. A request is either a single-word write or
// a read burst of 1..8 consecutive words; burst addresses wrap modulo 2^ADDR_W.
// Each read word takes three states: RD_ADDR presents the address, RD_CAP
// captures the memory output, and RD_RESP holds the word until the core
// consumes it.
//
// Ports
//   clock        single clock, all state changes on the rising edge
//   reset        synchronous active-high reset, wins over every handshake
//   req_valid    core request present
//   req_ready    controller accepts a request this cycle (IDLE, reset low)
//   req_write    1 = single-word write, 0 = burst read
//   req_addr     start word address
//   req_len      read burst length minus one (ignored for writes)
//   req_wdata    write data
//   resp_valid   resp_data holds a read word
//   resp_ready   core consumes the read word
//   resp_data    read word
//   resp_last    marks the final word of a burst
//   wr_done      one-cycle pulse after a write has been performed
//   mem_address  data-memory address
//   mem_read     1 = memory reads, 0 = memory writes mem_wdata on that edge
//   mem_wdata    data-memory write data
//   mem_rdata    data-memory registered read output
// ---------------------------------------------------------------------------
module data_mem_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_len,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_last,
    output logic              wr_done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_CAP  = 3'd2,
        RD_RESP = 3'd3,
        WR      = 3'd4,
        WR_DONE = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [2:0]          r_cnt;          // words still to deliver after the current one
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_resp_data;
    logic                r_resp_last;
    logic                r_resp_valid;
    logic                r_wr_done;
    logic                r_mem_read;

    logic                w_accept;
    logic                w_resp_hs;
    logic                w_more;

    // Ready is a decode of the state register, gated so nothing is taken while reset is high
    assign req_ready = (r_state == IDLE) && !reset;
    assign w_accept  = req_valid && req_ready;
    // resp_valid is high throughout RD_RESP, so state plus resp_ready is the handshake
    assign w_resp_hs = (r_state == RD_RESP) && resp_ready;
    assign w_more    = (r_cnt != 3'd0);

    assign resp_valid  = r_resp_valid;
    assign resp_data   = r_resp_data;
    assign resp_last   = r_resp_last;
    assign wr_done     = r_wr_done;
    assign mem_address = r_addr;
    assign mem_read    = r_mem_read;
    assign mem_wdata   = r_wdata;

    // Next-state decode for the request sequencer
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = req_write ? WR : RD_ADDR;
                end else begin
                    w_next_state = IDLE;
                end
            end
            RD_ADDR: w_next_state = RD_CAP;
            RD_CAP:  w_next_state = RD_RESP;
            RD_RESP: begin
                if (w_resp_hs) begin
                    w_next_state = w_more ? RD_ADDR : IDLE;
                end else begin
                    w_next_state = RD_RESP;
                end
            end
            WR:      w_next_state = WR_DONE;
            WR_DONE: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // State register and the status outputs, which are registered from the next state
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_mem_read   <= 1'b1;
            r_resp_valid <= 1'b0;
            r_wr_done    <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            // The memory writes on every edge where mem_read is low, so it is low only in WR
            r_mem_read   <= (w_next_state != WR);
            r_resp_valid <= (w_next_state == RD_RESP);
            r_wr_done    <= (w_next_state == WR_DONE);
        end
    end

    // Request latch, burst address/count stepping and read-word capture
    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr      <= {ADDR_W{1'b0}};
            r_cnt       <= 3'd0;
            r_wdata     <= {DATA_W{1'b0}};
            r_resp_data <= {DATA_W{1'b0}};
            r_resp_last <= 1'b0;
        end else if (w_accept) begin
            r_addr  <= req_addr;
            r_cnt   <= req_len;
            r_wdata <= req_wdata;
        end else if (r_state == RD_CAP) begin
            r_resp_data <= mem_rdata;
            r_resp_last <= (r_cnt == 3'd0);
        end else if (w_resp_hs && w_more) begin
            // Natural ADDR_W-bit overflow gives the modulo-2^ADDR_W wrap
            r_addr <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
            r_cnt  <= r_cnt - 3'd1;
        end else begin
            r_addr <= r_addr;
        end
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, meaning memory word-address width (32 words).
REQ-002 SHALL have parameter DATA_W, default 16, meaning memory word width.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  core request present.
REQ-006 SHALL have port req_ready  output  1  controller accepts a request this cycle.
REQ-007 SHALL have port req_write  input  1  1 = single-word write, 0 = burst read.
REQ-008 SHALL have port req_addr  input  ADDR_W  start word address.
REQ-009 SHALL have port req_len  input  3  read burst length minus one (1..8 words); ignored for writes.
REQ-010 SHALL have port req_wdata  input  DATA_W  write data.
REQ-011 SHALL have port resp_valid  output  1  resp_data holds a read word.
REQ-012 SHALL have port resp_ready  input  1  core consumes the read word.
REQ-013 SHALL have port resp_data  output  DATA_W  read word.
REQ-014 SHALL have port resp_last  output  1  qualifies the final word of a burst.
REQ-015 SHALL have port wr_done  output  1  one-cycle pulse when a write has completed.
REQ-016 SHALL have port mem_address  output  ADDR_W  data-memory address.
REQ-017 SHALL have port mem_read  output  1  1 = memory reads, 0 = memory writes mem_wdata on that edge.
REQ-018 SHALL have port mem_wdata  output  DATA_W  data-memory write data.
REQ-019 SHALL have port mem_rdata  input  DATA_W  data-memory registered read output (valid the cycle after the read edge).

Function
REQ-020 SHALL implement states IDLE, RD_ADDR, RD_CAP, RD_RESP, WR, WR_DONE.
REQ-021 SHALL drive req_ready=1 only in IDLE with reset low; a request is accepted on an edge with req_valid&req_ready.
REQ-022 SHALL hold mem_read=1 in every state except WR; WR lasts exactly one cycle (the memory writes on every edge with mem_read=0).
REQ-023 On read accept in cycle 0: cycle 1 RD_ADDR drives mem_address=addr, mem_read=1; cycle 2 RD_CAP registers mem_rdata into resp_data; cycle 3 RD_RESP asserts resp_valid.
REQ-024 SHALL hold resp_valid, resp_data, resp_last stable in RD_RESP until resp_ready=1; the handshake edge deasserts resp_valid.
REQ-025 After a read handshake with words remaining, SHALL go to RD_ADDR with address+1; minimum 3 cycles per word.
REQ-026 SHALL compute burst addresses modulo 2^ADDR_W (31 wraps to 0).
REQ-027 SHALL assert resp_last with the word number req_len+1, then return to IDLE after its handshake.
REQ-028 On write accept in cycle 0: cycle 1 WR drives mem_address=addr, mem_wdata=wdata, mem_read=0; cycle 2 WR_DONE pulses wr_done=1; cycle 3 IDLE.
REQ-029 SHALL latch req_addr, req_len, req_write, req_wdata at acceptance; later changes on req_* have no effect.
REQ-030 SHALL ignore req_valid in all non-IDLE states (no queuing).
REQ-031 resp_ready outside RD_RESP SHALL have no effect.

Reset
REQ-032 While reset=1 at an edge: state=IDLE, mem_read=1, mem_address=0, mem_wdata=0, resp_valid=0, resp_data=0, resp_last=0, wr_done=0, req_ready=0.
REQ-033 Reset mid-burst or in WR SHALL abort the operation: no further resp_valid or wr_done, and mem_read=1 from the cycle after the reset edge.
REQ-034 reset SHALL take priority over every simultaneous handshake.

Verification (memory model preloaded mem[i]=i)
REQ-035 Read addr=5, len=0, resp_ready=1 -> resp_valid in cycle 3 after accept, resp_data=5, resp_last=1; req_ready=1 next cycle.
REQ-036 Read addr=30, len=3 -> words 30,31,0,1 in order, resp_last only with 1, mem_read never 0.
REQ-037 Write addr=7, wdata=0xBEEF, then read addr=7 -> mem_read=0 for exactly one cycle, wr_done one pulse, read returns 0xBEEF.
REQ-038 Read addr=2, len=1, resp_ready=0 for 5 cycles -> resp_valid and resp_data=2 held stable, no address advance; releasing resp_ready yields word 3.
REQ-039 Reset asserted during RD_RESP of a len=7 burst -> resp_valid=0 next cycle, no further words, req_ready=1 after reset falls.
REQ-040 req_valid held high with changing req_addr during a burst -> no second acceptance until IDLE; returned data matches the latched address.
